// File: rtl/calc_inv_ctrl_if.sv
// Host-side stream bundle for calc_inv_ctrl: 32-bit operand input stream (s_*)
// and 32-bit result output stream (m_*). The controller uses the slave modport,
// the host side uses the master modport.
interface calc_inv_ctrl_if;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic        m_last;

   modport slave (
      input  s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data, m_last
   );

   modport master (
      output s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data, m_last
   );
endinterface

// File: rtl/calc_inv_ctrl.sv
// calc_inv_ctrl: gathers a 128-bit operand as four 32-bit beats, pulses the
// inversion engine once, waits for done with a timeout, then drains the
// 128-bit result as four 32-bit beats.
// Optional feature macro: CALC_INV_CTRL_CHECK_EN (result == ~operand checker).
module calc_inv_ctrl #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic           clk,
   input  logic           rst,
   calc_inv_ctrl_if.slave bus,
   output logic           eng_en,
   output logic [127:0]   eng_data,
   input  logic [127:0]   eng_result,
   input  logic           eng_done,
   output logic           busy,
   output logic           err,
   output logic           mismatch
);

   localparam logic [1:0] GATHER = 2'd0;
   localparam logic [1:0] ISSUE  = 2'd1;
   localparam logic [1:0] WAIT   = 2'd2;
   localparam logic [1:0] DRAIN  = 2'd3;

   localparam logic [7:0] TMO_MAX = 8'(TIMEOUT);

   logic [1:0]   state_q, state_d;
   logic [1:0]   beat_q, beat_d;
   logic [7:0]   tmo_q, tmo_d;
   logic         err_q, err_d;
   logic         capture;
   logic [95:0]  op_q;
   logic [127:0] eng_data_q;
   logic [127:0] res_q;
   logic         s_fire, m_fire;

   assign s_fire = bus.s_valid && bus.s_ready;
   assign m_fire = bus.m_valid && bus.m_ready;

   // Next-state logic for the FSM, beat counter, timeout counter and error flag
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      tmo_d   = tmo_q;
      err_d   = err_q;
      capture = 1'b0;
      case (state_q)
         GATHER: begin
            if (s_fire) begin
               beat_d = beat_q + 2'd1;
               if (beat_q == 2'd3) state_d = ISSUE;
            end
         end
         ISSUE: begin
            tmo_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // done takes priority over an expiring timeout
            if (eng_done) begin
               capture = 1'b1;
               state_d = DRAIN;
            end else begin
               tmo_d = tmo_q + 8'd1;
               if (tmo_q + 8'd1 == TMO_MAX) begin
                  err_d   = 1'b1;
                  state_d = GATHER;
               end
            end
         end
         DRAIN: begin
            if (m_fire) begin
               beat_d = beat_q + 2'd1;
               if (beat_q == 2'd3) state_d = GATHER;
            end
         end
         default: state_d = GATHER;
      endcase
   end

   // State, operand slots, engine operand and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= GATHER;
         beat_q     <= '0;
         tmo_q      <= '0;
         err_q      <= 1'b0;
         op_q       <= '0;
         eng_data_q <= '0;
         res_q      <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
         if (state_q == GATHER && s_fire) begin
            case (beat_q)
               2'd0:    op_q[31:0]  <= bus.s_data;
               2'd1:    op_q[63:32] <= bus.s_data;
               2'd2:    op_q[95:64] <= bus.s_data;
               // The engine operand only changes once a full new operand is in
               default: eng_data_q  <= {bus.s_data, op_q};
            endcase
         end
         if (capture) res_q <= eng_result;
      end
   end

`ifdef CALC_INV_CTRL_CHECK_EN
   logic mismatch_q;

   // Sticky flag: captured result differs from the bitwise inverse of the operand
   always_ff @(posedge clk) begin
      if (rst) begin
         mismatch_q <= 1'b0;
      end else if (capture && (eng_result != ~eng_data_q)) begin
         mismatch_q <= 1'b1;
      end
   end

   assign mismatch = mismatch_q;
`else
   assign mismatch = 1'b0;
`endif

   assign bus.s_ready = (state_q == GATHER);
   assign bus.m_valid = (state_q == DRAIN);
   // Data is gated outside DRAIN so the idle output reads 0
   assign bus.m_data  = (state_q == DRAIN) ? res_q[{beat_q, 5'd0} +: 32] : 32'd0;
   assign bus.m_last  = (state_q == DRAIN) && (beat_q == 2'd3);
   assign eng_en      = (state_q == ISSUE);
   assign eng_data    = eng_data_q;
   assign busy        = (state_q != GATHER);
   assign err         = err_q;

endmodule

// File: tb/tb_calc_inv_ctrl.sv
// Directed self-checking bench for calc_inv_ctrl with a one-cycle engine model.
module tb_calc_inv_ctrl;

   logic         clk;
   logic         rst;
   logic         eng_en;
   logic [127:0] eng_data;
   logic [127:0] eng_result;
   logic         eng_done;
   logic         busy;
   logic         err;
   logic         mismatch;

   calc_inv_ctrl_if bus ();

   calc_inv_ctrl #(.TIMEOUT(15)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .eng_en     (eng_en),
      .eng_data   (eng_data),
      .eng_result (eng_result),
      .eng_done   (eng_done),
      .busy       (busy),
      .err        (err),
      .mismatch   (mismatch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Engine model: done one cycle after enable, result = ~operand ^ flip
   logic         eng_on;
   logic         flip;
   logic         stray;
   logic         done_m;
   logic [127:0] res_m;

   always @(posedge clk) begin
      if (rst) begin
         done_m <= 1'b0;
         res_m  <= '0;
      end else begin
         done_m <= eng_en && eng_on;
         if (eng_en) res_m <= ~eng_data ^ {127'd0, flip};
      end
   end

   assign eng_done   = done_m | stray;
   assign eng_result = stray ? 128'h0123_4567_89AB_CDEF_0F0F_0F0F_F0F0_F0F0 : res_m;

   int          tests;
   int          fails;
   int          cyc;
   int          en_cnt;
   int          en_cyc;
   int          err_cyc;
   int          stall_bad;
   int          vcnt;
   bit          err_seen;
   logic [32:0] outq[$];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: record handshakes seen by the coming edge, then move to the next negedge
   task automatic tick();
      logic        stall;
      logic [31:0] pd;
      logic        pl;
      stall = bus.m_valid && !bus.m_ready && !rst;
      pd    = bus.m_data;
      pl    = bus.m_last;
      if (bus.m_valid && bus.m_ready && !rst) outq.push_back({bus.m_last, bus.m_data});
      if (eng_en && !rst) begin
         en_cnt++;
         en_cyc = cyc;
      end
      @(negedge clk);
      cyc++;
      if (stall && (bus.m_data !== pd || bus.m_last !== pl)) stall_bad++;
      if (err && !err_seen) begin
         err_seen = 1'b1;
         err_cyc  = cyc;
      end
   endtask

   task automatic send_req(input logic [127:0] op);
      for (int i = 0; i < 4; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = op[i*32 +: 32];
         tick();
      end
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
   endtask

   task automatic wait_gather(input string tag);
      for (int i = 0; i < 40 && busy; i++) tick();
      chk(tag, busy, 1'b0);
   endtask

   task automatic check_out(input string tag, input logic [127:0] exp_res);
      chk({tag, "_count"}, outq.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < outq.size()) begin
            chk($sformatf("%s_beat%0d", tag, i), outq[i], {(i == 3), exp_res[i*32 +: 32]});
         end
      end
   endtask

   logic [127:0] op;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tests = 0; fails = 0; cyc = 0; en_cnt = 0; en_cyc = 0; err_cyc = 0;
      stall_bad = 0; err_seen = 1'b0;
      rst = 1'b1; eng_on = 1'b1; flip = 1'b0; stray = 1'b0;
      bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b1;

      // Reset
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("rst_s_ready", bus.s_ready, 1'b1);
      chk("rst_eng_en", eng_en, 1'b0);
      chk("rst_eng_data", eng_data, 128'd0);
      chk("rst_m_valid", bus.m_valid, 1'b0);
      chk("rst_m_data", bus.m_data, 32'd0);
      chk("rst_m_last", bus.m_last, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_mismatch", mismatch, 1'b0);

      // Single request with latency checks
      outq.delete(); en_cnt = 0;
      send_req(128'hA5A5A5A5_12345678_FFFFFFFF_00000000);
      chk("lat_issue_en", eng_en, 1'b1);
      chk("lat_issue_data", eng_data, 128'hA5A5A5A5_12345678_FFFFFFFF_00000000);
      chk("lat_issue_s_ready", bus.s_ready, 1'b0);
      tick();
      chk("lat_wait_en", eng_en, 1'b0);
      chk("lat_wait_done", eng_done, 1'b1);
      tick();
      chk("lat_drain0_valid", bus.m_valid, 1'b1);
      chk("lat_drain0_data", bus.m_data, 32'hFFFFFFFF);
      chk("lat_drain0_last", bus.m_last, 1'b0);
      tick(); tick(); tick();
      chk("lat_drain3_data", bus.m_data, 32'h5A5A5A5A);
      chk("lat_drain3_last", bus.m_last, 1'b1);
      tick();
      chk("lat_s_ready_again", bus.s_ready, 1'b1);
      chk("single_en_pulses", en_cnt, 1);
      chk("single_out_count", outq.size(), 4);
      if (outq.size() == 4) begin
         chk("single_b0", outq[0], {1'b0, 32'hFFFFFFFF});
         chk("single_b1", outq[1], {1'b0, 32'h00000000});
         chk("single_b2", outq[2], {1'b0, 32'hEDCBA987});
         chk("single_b3", outq[3], {1'b1, 32'h5A5A5A5A});
      end
      chk("single_err", err, 1'b0);
      chk("single_mismatch", mismatch, 1'b0);

      // Backpressure: stall 5 cycles then toggle m_ready
      outq.delete(); stall_bad = 0;
      op = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
      bus.m_ready = 1'b0;
      send_req(op);
      for (int i = 0; i < 10 && !bus.m_valid; i++) tick();
      chk("bp_valid", bus.m_valid, 1'b1);
      for (int i = 0; i < 5; i++) tick();
      chk("bp_stalled_none", outq.size(), 0);
      for (int i = 0; i < 20 && busy; i++) begin
         bus.m_ready = !bus.m_ready;
         tick();
      end
      bus.m_ready = 1'b1;
      chk("bp_done", busy, 1'b0);
      chk("bp_stable", stall_bad, 0);
      check_out("bp", ~op);

      // Timeout: engine silent
      outq.delete(); err_seen = 1'b0; eng_on = 1'b0;
      send_req(128'h11111111_22222222_33333333_44444444);
      for (int i = 0; i < 40 && !err_seen; i++) tick();
      chk("tmo_err", err, 1'b1);
      chk("tmo_delay", err_cyc - en_cyc, 16);
      chk("tmo_s_ready", bus.s_ready, 1'b1);
      chk("tmo_no_out", outq.size(), 0);
      eng_on = 1'b1;
      op = 128'hDEADBEEF_CAFEF00D_0BADC0DE_55AA55AA;
      send_req(op);
      wait_gather("tmo_next_done");
      check_out("tmo_next", ~op);
      chk("tmo_err_sticky", err, 1'b1);

      // Reset after two beats
      outq.delete();
      bus.s_valid = 1'b1; bus.s_data = 32'h99999999; tick();
      bus.s_data = 32'h88888888; tick();
      bus.s_valid = 1'b0;
      rst = 1'b1; tick(); rst = 1'b0;
      chk("rstmid_err_clr", err, 1'b0);
      chk("rstmid_idle", busy, 1'b0);
      op = 128'h76543210_FEDCBA98_13579BDF_2468ACE0;
      send_req(op);
      chk("rstmid_eng_data", eng_data, op);
      wait_gather("rstmid_done");
      check_out("rstmid", ~op);

      // Reset during DRAIN beat 1
      outq.delete();
      op = 128'hC0C0C0C0_B0B0B0B0_A0A0A0A0_90909090;
      send_req(op);
      for (int i = 0; i < 10 && !bus.m_valid; i++) tick();
      tick();
      chk("rstdrain_beat1", bus.m_data, 32'h5F5F5F5F);
      rst = 1'b1; tick(); rst = 1'b0;
      vcnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus.m_valid) vcnt++;
         tick();
      end
      chk("rstdrain_no_valid", vcnt, 0);
      chk("rstdrain_beats", outq.size(), 1);

      // Stray done in GATHER, then a faulty engine result
      outq.delete();
      tick();
      stray = 1'b1; tick(); stray = 1'b0;
      tick();
      chk("stray_busy", busy, 1'b0);
      chk("stray_m_valid", bus.m_valid, 1'b0);
      chk("stray_err", err, 1'b0);
      chk("stray_mismatch", mismatch, 1'b0);
      flip = 1'b1;
      op = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
      send_req(op);
      wait_gather("chk_done");
      check_out("chk", ~op ^ 128'd1);
`ifdef CALC_INV_CTRL_CHECK_EN
      chk("chk_mismatch", mismatch, 1'b1);
`else
      chk("chk_mismatch", mismatch, 1'b0);
`endif
      chk("chk_err", err, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
